sha_msg_padder: RTL and testbench
=================================

Name: sha_msg_padder

Overview:
- Front end of the SHA-256 core.
- Accepts a raw message as a byte stream and produces the 512-bit padded blocks the core consumes on its message input.
- Padding per FIPS 180-4: append 0x80, zero-fill, then the 64-bit big-endian message bit length.
- Emits one extra block when the tail leaves fewer than 9 free bytes.

Parameters:
- CNT_W, 32, width of the internal message byte counter. Maximum message length is 2^CNT_W-1 bytes. Must be 1..61.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- s_data  in  8  message byte
- s_valid  in  1  s_data valid
- s_last  in  1  qualifies the final byte of the message (with s_valid)
- s_ready  out  1  padder accepts a byte this cycle
- blk_data  out  512  padded block; byte 0 in bits [511:504], byte 63 in [7:0]
- blk_valid  out  1  blk_data valid
- blk_ready  in  1  SHA core takes the block
- blk_first  out  1  block is the first of its message (valid with blk_valid)
- blk_last  out  1  block is the final block of its message (valid with blk_valid)

Behaviour:
- Reset (rst=0, async): state=FILL, buffer=0, byte position p=0, byte count=0. Outputs: s_ready=0 while in reset, then 1; blk_valid=0; blk_first=0; blk_last=0; blk_data=0.
- State FILL:
  - s_ready=1, blk_valid=0.
  - On s_valid&s_ready, store s_data at byte p, p++, count++.
  - Full block, non-last (p==63 written, s_last=0): go to EMIT with last=0.
  - s_last accepted at position p:
    - If p<=62, write 0x80 at p+1.
    - Bytes p+2..63 are already zero.
    - If p<=54: write bit length at bytes 56..63 and go to EMIT with last=1.
    - Else: go to EMIT with last=0 and extra=1. Record need80=(p==63).
- State EMIT:
  - s_ready=0, blk_valid=1.
  - blk_data, blk_first and blk_last are held stable until blk_ready is sampled high.
  - On the blk_valid&blk_ready cycle: clear buffer, p=0.
    - extra=1 → go to EXTRA.
    - last=1 → count=0, first-flag set, go to FILL.
    - Otherwise → go to FILL.
- State EXTRA (one cycle):
  - Build the block: byte 0 = 0x80 if need80 else 0x00; bit length in bytes 56..63; zeros elsewhere.
  - Go to EMIT with last=1, extra=0. s_ready=0.
- Bit length: {count,3'b000}, zero-extended to 64 bits, big-endian. The value captured is count including the final byte.
- blk_first: 1 on the first block after reset or after a blk_last handshake; 0 otherwise.
- Latency: blk_valid rises the cycle after the byte that completes the block is accepted. In the extra-block case, the second block follows 2 cycles after the first handshake.
- Throughput: 64 byte cycles + 1 emit cycle minimum per block. Bytes are never accepted while in EMIT or EXTRA.
- Messages are at least 1 byte; s_last without s_valid is ignored.
- Reset mid-message or mid-EMIT: the partial block is discarded and no block is output. Clean restart with blk_first=1.
- Count overflow without the feature: count wraps modulo 2^CNT_W.

Optional Feature:
- Macro: SHA_PAD_ERR_EN.
- Defined:
  - Adds output port err (1 bit, reset 0).
  - err goes high and stays sticky when a byte is accepted with count==2^CNT_W-1.
  - Once err is high, s_ready=0 until reset.
  - Any block in progress is dropped.
- Undefined: port err is absent, no check is made, and count wraps.

Test Plan:
- "abc" (0x61,0x62,0x63, s_last on 0x63), blk_ready=1 → one block, first=1, last=1, 0x61626380 followed by zeros with low 64 bits 0x...18.
- 55 bytes of 0x00 → single block: byte 55 = 0x80, length 0x1B8, last=1.
- 56 bytes of 0xFF:
  - Block 1: bytes 0..55 = 0xFF, byte 56 = 0x80, rest 0, first=1, last=0.
  - Block 2: all zero except length 0x1C0, first=0, last=1.
- 64 bytes of 0xAA:
  - Block 1: all 0xAA, last=0.
  - Block 2: byte 0 = 0x80, length 0x200, last=1.
- Backpressure: hold blk_ready=0 for 10 cycles on the "abc" block → blk_valid and data stable, s_ready=0 throughout. Block accepted on the first blk_ready=1 cycle, then s_ready=1.
- Reset mid-message: assert rst=0 after 30 bytes, then send "abc" → exactly one block, identical to the first scenario. Under SHA_PAD_ERR_EN with CNT_W=4, a 16-byte message → err=1 on the 16th byte and s_ready=0.

Source files
------------

// File: rtl/sha_msg_padder.sv
// SHA-256 message padder: packs a byte stream into 512-bit blocks and
// appends FIPS 180-4 padding (0x80, zero fill, 64-bit big-endian bit length).
// Adds a second block when fewer than 9 bytes are left free in the tail block.
//
// Optional build macro SHA_PAD_ERR_EN adds a sticky 'err' output that fires
// when a byte arrives while the byte counter is already saturated; the
// block in progress is dropped and input stays blocked until reset.

module sha_msg_padder #(
    parameter int unsigned CNT_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   s_data,
    input  logic         s_valid,
    input  logic         s_last,
    output logic         s_ready,
    output logic [511:0] blk_data,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic         blk_first,
    output logic         blk_last
`ifdef SHA_PAD_ERR_EN
    ,
    output logic         err
`endif
);

    localparam logic [1:0] StFill  = 2'd0;
    localparam logic [1:0] StEmit  = 2'd1;
    localparam logic [1:0] StExtra = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [511:0]     buf_q, buf_d;
    logic [5:0]       pos_q, pos_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             extra_q, extra_d;
    logic             need80_q, need80_d;
    logic             first_q, first_d;
    logic             blocked;
    logic             accept;
    logic [CNT_W-1:0] cnt_inc;
    int               byte_msb;

`ifdef SHA_PAD_ERR_EN
    logic err_q, err_d;
    assign blocked = err_q;
    assign err     = err_q;
`else
    assign blocked = 1'b0;
`endif

    // Message length in bits, zero-extended to the 64-bit length field.
    function automatic logic [63:0] bit_len(input logic [CNT_W-1:0] c);
        logic [63:0] r;
        r = '0;
        r[CNT_W+2:0] = {c, 3'b000};
        return r;
    endfunction

    // Input is only taken while filling; held low during reset.
    assign s_ready   = rst && (state_q == StFill) && !blocked;
    assign accept    = s_valid && s_ready;
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign byte_msb  = 511 - 8 * int'(pos_q);

    assign blk_valid = (state_q == StEmit);
    assign blk_data  = buf_q;
    assign blk_first = blk_valid && first_q;
    assign blk_last  = blk_valid && last_q;

    // Next-state logic: byte packing, padding insertion and block handoff.
    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        pos_d    = pos_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        extra_d  = extra_q;
        need80_d = need80_q;
        first_d  = first_q;
`ifdef SHA_PAD_ERR_EN
        err_d    = err_q;
`endif

        unique case (state_q)
            StFill: begin
                if (accept) begin
                    buf_d[byte_msb -: 8] = s_data;
                    pos_d = pos_q + 6'd1;
                    cnt_d = cnt_inc;
                    if (s_last) begin
                        if (pos_q != 6'd63) begin
                            buf_d[byte_msb - 8 -: 8] = 8'h80;
                        end
                        if (pos_q <= 6'd54) begin
                            // Length fits behind the 0x80 marker in this block.
                            buf_d[63:0] = bit_len(cnt_inc);
                            state_d     = StEmit;
                            last_d      = 1'b1;
                            extra_d     = 1'b0;
                        end else begin
                            // Tail too short for the length; it goes in an extra block,
                            // along with the 0x80 marker if there was no room for it.
                            state_d  = StEmit;
                            last_d   = 1'b0;
                            extra_d  = 1'b1;
                            need80_d = (pos_q == 6'd63);
                        end
                    end else if (pos_q == 6'd63) begin
                        state_d = StEmit;
                        last_d  = 1'b0;
                        extra_d = 1'b0;
                    end
                end
            end

            StEmit: begin
                if (blk_ready) begin
                    buf_d   = '0;
                    pos_d   = '0;
                    first_d = last_q;
                    if (extra_q) begin
                        state_d = StExtra;
                    end else begin
                        state_d = StFill;
                        if (last_q) begin
                            cnt_d = '0;
                        end
                    end
                end
            end

            StExtra: begin
                buf_d          = '0;
                buf_d[511:504] = need80_q ? 8'h80 : 8'h00;
                buf_d[63:0]    = bit_len(cnt_q);
                state_d        = StEmit;
                last_d         = 1'b1;
                extra_d        = 1'b0;
                need80_d       = 1'b0;
            end

            default: begin
                state_d = StFill;
            end
        endcase

`ifdef SHA_PAD_ERR_EN
        // Counter saturated: flag it and throw away the partial block.
        if (accept && (cnt_q == '1)) begin
            err_d    = 1'b1;
            state_d  = StFill;
            buf_d    = '0;
            pos_d    = '0;
            last_d   = 1'b0;
            extra_d  = 1'b0;
            need80_d = 1'b0;
        end
`endif
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StFill;
            buf_q    <= '0;
            pos_q    <= '0;
            cnt_q    <= '0;
            last_q   <= 1'b0;
            extra_q  <= 1'b0;
            need80_q <= 1'b0;
            first_q  <= 1'b1;
`ifdef SHA_PAD_ERR_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            buf_q    <= buf_d;
            pos_q    <= pos_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            extra_q  <= extra_d;
            need80_q <= need80_d;
            first_q  <= first_d;
`ifdef SHA_PAD_ERR_EN
            err_q    <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_sha_msg_padder.sv
// Directed bench for sha_msg_padder: known padding vectors, extra-block
// cases, backpressure, mid-message reset and (with SHA_PAD_ERR_EN) overflow.

module tb_sha_msg_padder;

`ifdef SHA_PAD_ERR_EN
    localparam int unsigned CW = 4;
`else
    localparam int unsigned CW = 32;
`endif
    localparam int MID = (CW < 8) ? 10 : 30;

    logic         clk;
    logic         rst;
    logic [7:0]   s_data;
    logic         s_valid;
    logic         s_last;
    logic         s_ready;
    logic [511:0] blk_data;
    logic         blk_valid;
    logic         blk_ready;
    logic         blk_first;
    logic         blk_last;
`ifdef SHA_PAD_ERR_EN
    logic         err;
`endif

    sha_msg_padder #(
        .CNT_W(CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_last   (s_last),
        .s_ready  (s_ready),
        .blk_data (blk_data),
        .blk_valid(blk_valid),
        .blk_ready(blk_ready),
        .blk_first(blk_first),
        .blk_last (blk_last)
`ifdef SHA_PAD_ERR_EN
        ,
        .err      (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Captured handshakes; inputs change at posedge+1, so negedge sees what
    // the next rising edge will act on.
    logic [511:0] q_data[$];
    logic         q_first[$];
    logic         q_last[$];
    int           q_cyc[$];

    always @(negedge clk) begin
        if (rst && blk_valid && blk_ready) begin
            q_data.push_back(blk_data);
            q_first.push_back(blk_first);
            q_last.push_back(blk_last);
            q_cyc.push_back(cyc);
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        q_data.delete();
        q_first.delete();
        q_last.delete();
        q_cyc.delete();
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        int guard = 0;
        while (!s_ready && guard < 500) begin
            s_valid = 1'b0;
            s_last  = 1'b0;
            step();
            guard++;
        end
        if (!s_ready) check_eq("s_ready_timeout", 512'(s_ready), 512'(1));
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        step();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_fill(input int n, input logic [7:0] v);
        for (int i = 0; i < n; i++) send_byte(v, i == n - 1);
    endtask

    task automatic send_abc();
        send_byte(8'h61, 1'b0);
        send_byte(8'h62, 1'b0);
        send_byte(8'h63, 1'b1);
    endtask

    task automatic wait_blocks(input string tag, input int n);
        int guard = 0;
        while (q_data.size() < n && guard < 300) begin
            step();
            guard++;
        end
        check_eq(tag, 512'(q_data.size()), 512'(n));
    endtask

    task automatic expect_blk(input string tag, input int idx, input logic [511:0] d,
                              input logic f, input logic l);
        if (idx < q_data.size()) begin
            check_eq({tag, "_data"}, q_data[idx], d);
            check_eq({tag, "_first"}, 512'(q_first[idx]), 512'(f));
            check_eq({tag, "_last"}, 512'(q_last[idx]), 512'(l));
        end else begin
            check_eq({tag, "_missing"}, 512'(q_data.size()), 512'(idx + 1));
        end
    endtask

    logic [511:0] e_abc, e1, e2;

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        e_abc = '0;
        e_abc[511:480] = 32'h61626380;
        e_abc[63:0]    = 64'h18;

        rst = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0; blk_ready = 1'b1;
        step();
        step();
        check_eq("rst_s_ready", 512'(s_ready), 512'(0));
        check_eq("rst_blk_valid", 512'(blk_valid), 512'(0));
        check_eq("rst_blk_first", 512'(blk_first), 512'(0));
        check_eq("rst_blk_last", 512'(blk_last), 512'(0));
        check_eq("rst_blk_data", blk_data, '0);
        rst = 1'b1;
        step();
        check_eq("post_rst_s_ready", 512'(s_ready), 512'(1));

        // "abc": single block, valid the cycle after the last byte.
        clear_q();
        send_abc();
        check_eq("abc_latency", 512'(blk_valid), 512'(1));
        wait_blocks("abc_count", 1);
        expect_blk("abc", 0, e_abc, 1'b1, 1'b1);

`ifndef SHA_PAD_ERR_EN
        // 55 zero bytes: marker and length both fit.
        clear_q();
        send_fill(55, 8'h00);
        wait_blocks("z55_count", 1);
        repeat (4) step();
        check_eq("z55_single", 512'(q_data.size()), 512'(1));
        e1 = '0;
        e1[71:64] = 8'h80;
        e1[63:0]  = 64'h1B8;
        expect_blk("z55", 0, e1, 1'b1, 1'b1);

        // 56 x 0xFF: marker in block 1, length in extra block.
        clear_q();
        send_fill(56, 8'hFF);
        wait_blocks("ff56_count", 2);
        e1 = '0;
        e1[511:64] = {56{8'hFF}};
        e1[63:56]  = 8'h80;
        e2 = '0;
        e2[63:0] = 64'h1C0;
        expect_blk("ff56_b1", 0, e1, 1'b1, 1'b0);
        expect_blk("ff56_b2", 1, e2, 1'b0, 1'b1);
        if (q_cyc.size() >= 2) check_eq("ff56_gap", 512'(q_cyc[1] - q_cyc[0]), 512'(2));

        // 64 x 0xAA: full block, marker and length in extra block.
        clear_q();
        send_fill(64, 8'hAA);
        wait_blocks("aa64_count", 2);
        e1 = {64{8'hAA}};
        e2 = '0;
        e2[511:504] = 8'h80;
        e2[63:0]    = 64'h200;
        expect_blk("aa64_b1", 0, e1, 1'b1, 1'b0);
        expect_blk("aa64_b2", 1, e2, 1'b0, 1'b1);

        // Backpressure: block held stable, input stalled.
        clear_q();
        blk_ready = 1'b0;
        send_abc();
        for (int i = 0; i < 10; i++) begin
            check_eq("bp_valid", 512'(blk_valid), 512'(1));
            check_eq("bp_data", blk_data, e_abc);
            check_eq("bp_s_ready", 512'(s_ready), 512'(0));
            check_eq("bp_first", 512'(blk_first), 512'(1));
            step();
        end
        check_eq("bp_none_yet", 512'(q_data.size()), 512'(0));
        blk_ready = 1'b1;
        step();
        check_eq("bp_taken", 512'(q_data.size()), 512'(1));
        check_eq("bp_s_ready_after", 512'(s_ready), 512'(1));
        check_eq("bp_valid_after", 512'(blk_valid), 512'(0));
`endif

        // Reset mid-message: partial data discarded, clean restart.
        send_fill(MID - 1, 8'h5A);
        send_byte(8'h5A, 1'b0);
        rst = 1'b0;
        step();
        check_eq("midrst_s_ready", 512'(s_ready), 512'(0));
        check_eq("midrst_valid", 512'(blk_valid), 512'(0));
        rst = 1'b1;
        step();
        clear_q();
        send_abc();
        wait_blocks("midrst_count", 1);
        repeat (5) step();
        check_eq("midrst_single", 512'(q_data.size()), 512'(1));
        expect_blk("midrst", 0, e_abc, 1'b1, 1'b1);

`ifdef SHA_PAD_ERR_EN
        // 16-byte message overflows a 4-bit counter on the final byte.
        clear_q();
        for (int i = 0; i < 15; i++) send_byte(8'h11, 1'b0);
        check_eq("err_before", 512'(err), 512'(0));
        send_byte(8'h11, 1'b1);
        check_eq("err_set", 512'(err), 512'(1));
        check_eq("err_s_ready", 512'(s_ready), 512'(0));
        check_eq("err_valid", 512'(blk_valid), 512'(0));
        repeat (5) step();
        check_eq("err_sticky", 512'(err), 512'(1));
        check_eq("err_no_block", 512'(q_data.size()), 512'(0));
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
